// File: rtl/vector_alu_pkg.sv
// ---------------------------------------------------------------------------
// vector_alu_pkg : shared constants, ALU op encoding and sequencer states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vector_alu_pkg;

  localparam int WIDTH        = 24;
  localparam int VECTOR_WIDTH = 8;
  localparam int MAX_LEN      = 64;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_MULT  = 3'b010,
    ALU_AND   = 3'b011,
    ALU_CMPLT = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_PASSA = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vector_alu.sv
// ---------------------------------------------------------------------------
// vector_alu : combinational per-lane ALU, results wrap modulo 2^WIDTH
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vector_alu
  import vector_alu_pkg::*;
#(
  parameter int WIDTH        = vector_alu_pkg::WIDTH,
  parameter int VECTOR_WIDTH = vector_alu_pkg::VECTOR_WIDTH
) (
  input  alu_op_e                            op_i,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] a_i,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] b_i,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] res_o
);

  for (genvar i = 0; i < VECTOR_WIDTH; i++) begin : g_lane
    always_comb begin
      res_o[i] = '0;
      case (op_i)
        ALU_ADD:   res_o[i] = a_i[i] + b_i[i];
        ALU_SUB:   res_o[i] = a_i[i] - b_i[i];
        ALU_MULT:  res_o[i] = a_i[i] * b_i[i];
        ALU_AND:   res_o[i] = a_i[i] & b_i[i];
        // Unsigned compare; the flag lands in bit 0
        ALU_CMPLT: res_o[i] = {{(WIDTH-1){1'b0}}, (a_i[i] < b_i[i])};
        ALU_SHL:   res_o[i] = a_i[i] << b_i[i];
        ALU_PASSA: res_o[i] = a_i[i];
        ALU_PASSB: res_o[i] = b_i[i];
        default:   res_o[i] = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/valu_sequencer.sv
// ---------------------------------------------------------------------------
// valu_sequencer : splits a vector command into lane beats through vector_alu
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module valu_sequencer
  import vector_alu_pkg::*;
#(
  parameter int WIDTH        = vector_alu_pkg::WIDTH,
  parameter int VECTOR_WIDTH = vector_alu_pkg::VECTOR_WIDTH,
  parameter int MAX_LEN      = vector_alu_pkg::MAX_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [2:0]                         cmd_op,
  input  logic [6:0]                         cmd_len,
  input  logic                               opnd_valid,
  output logic                               opnd_ready,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] opnd_a,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] opnd_b,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] res_data,
  output logic [VECTOR_WIDTH-1:0]            res_lane_mask,
  output logic                               res_last,
  output logic                               busy,
  output logic                               done
);

  localparam int                LEN_W     = 7;
  localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  VW_C      = LEN_W'(VECTOR_WIDTH);

  state_e                             state_q, state_d;
  alu_op_e                            op_q, op_d;
  logic [LEN_W-1:0]                   len_q, len_d;
  logic [LEN_W-1:0]                   cnt_q, cnt_d;
  logic                               res_valid_q, res_valid_d;
  logic                               last_q, last_d;
  logic                               done_q, done_d;
  logic [VECTOR_WIDTH-1:0]            mask_q, mask_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data_q, data_d;

  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] alu_res;
  logic [VECTOR_WIDTH-1:0]            last_mask, beat_mask;
  logic [LEN_W-1:0]                   eff_len, beats, rem_raw, rem;
  logic                               cmd_hs, opnd_hs, res_hs, final_beat;

  vector_alu #(
    .WIDTH       (WIDTH),
    .VECTOR_WIDTH(VECTOR_WIDTH)
  ) u_alu (
    .op_i (op_q),
    .a_i  (opnd_a),
    .b_i  (opnd_b),
    .res_o(alu_res)
  );

  // Outputs are forced quiet while rst is high, independent of register contents
  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign opnd_ready    = (state_q == ST_RUN) && (!res_valid_q || res_ready) && !rst;
  assign busy          = (state_q != ST_IDLE) && !rst;
  assign done          = done_q && !rst;
  assign res_valid     = res_valid_q && !rst;
  assign res_last      = last_q && res_valid_q && !rst;
  assign res_lane_mask = rst ? '0 : mask_q;
  assign res_data      = data_q;

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign opnd_hs = opnd_valid && opnd_ready;
  assign res_hs  = res_valid && res_ready;

  always_comb begin
    eff_len    = (cmd_len > MAX_LEN_C) ? MAX_LEN_C : cmd_len;
    beats      = (len_q + VW_C - LEN_W'(1)) / VW_C;
    rem_raw    = len_q % VW_C;
    rem        = (rem_raw == '0) ? VW_C : rem_raw;
    final_beat = (cnt_q == beats - LEN_W'(1));
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      last_mask[i] = (LEN_W'(i) < rem);
    end
    beat_mask = final_beat ? last_mask : '1;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    data_d      = data_q;
    mask_d      = mask_q;
    last_d      = last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          op_d  = alu_op_e'(cmd_op);
          len_d = eff_len;
          cnt_d = '0;
          if (eff_len == '0) done_d = 1'b1;
          else               state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (opnd_hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (final_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_hs && last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Single-entry output register: a new beat overwrites a departing one
    if (opnd_hs) begin
      res_valid_d = 1'b1;
      mask_d      = beat_mask;
      last_d      = final_beat;
      for (int i = 0; i < VECTOR_WIDTH; i++) begin
        data_d[i] = beat_mask[i] ? alu_res[i] : '0;
      end
    end else if (res_hs) begin
      res_valid_d = 1'b0;
      last_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= ALU_ADD;
      len_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_valu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_valu_sequencer : directed and random command runs against a beat-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_valu_sequencer;

  localparam int W  = 24;
  localparam int VW = 8;
  localparam int ML = 64;

  typedef logic [VW-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [6:0]    cmd_len;
  logic          opnd_valid, opnd_ready;
  vec_t          opnd_a, opnd_b;
  logic          res_valid, res_ready;
  vec_t          res_data;
  logic [VW-1:0] res_lane_mask;
  logic          res_last, busy, done;

  int checks = 0;
  int errors = 0;

  vec_t a_q[$];
  vec_t b_q[$];

  always #5 clk = ~clk;

  valu_sequencer #(.WIDTH(W), .VECTOR_WIDTH(VW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_lane_mask(res_lane_mask), .res_last(res_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [W-1:0] lane_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      0: return a + b;
      1: return a - b;
      2: return p[W-1:0];
      3: return a & b;
      4: return (a < b) ? W'(1) : W'(0);
      5: return (b >= W) ? W'(0) : (a << b);
      6: return a;
      default: return b;
    endcase
  endfunction

  function automatic vec_t rand_vec(input int max_val);
    vec_t v;
    for (int i = 0; i < VW; i++) v[i] = W'($urandom_range(0, max_val));
    return v;
  endfunction

  task automatic fill_const(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t va, vb;
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < VW; i++) begin
      va[i] = a;
      vb[i] = b;
    end
    for (int k = 0; k < n; k++) begin
      a_q.push_back(va);
      b_q.push_back(vb);
    end
  endtask

  task automatic fill_rand(input int n, input int op);
    a_q.delete();
    b_q.delete();
    for (int k = 0; k < n; k++) begin
      a_q.push_back(rand_vec(32'h00FF_FFFF));
      b_q.push_back(rand_vec((op == 5) ? W + 2 : 32'h00FF_FFFF));
    end
  endtask

  task automatic issue(input int op, input int len);
    cmd_valid  = 1'b1;
    cmd_op     = 3'(op);
    cmd_len    = 7'(len);
    opnd_valid = 1'b1;
    res_ready  = 1'b0;
    settle();
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    chk("opnd_ready_idle", opnd_ready, 1'b0);
    tick();
    cmd_valid  = 1'b0;
    opnd_valid = 1'b0;
  endtask

  // vld_mode: 0 always valid, 1 random. rdy_mode: 0 always ready, 1 random, 2 stall 4 cycles.
  task automatic run(input int op, input int len, input int vld_mode, input int rdy_mode);
    int eff, beats, r, sent, got, cyc, hold;
    logic occ, held, ohs, rhs;
    vec_t exp_d[$];
    logic [VW-1:0] exp_m[$];
    vec_t d, prev_d;
    logic [VW-1:0] m, prev_m;
    logic prev_l;

    eff   = (len > ML) ? ML : len;
    beats = (eff + VW - 1) / VW;
    r     = eff % VW;
    if (r == 0) r = VW;
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < VW; i++) begin
        m[i] = (k < beats - 1) || (i < r);
        d[i] = m[i] ? lane_ref(op, a_q[k][i], b_q[k][i]) : W'(0);
      end
      exp_d.push_back(d);
      exp_m.push_back(m);
    end

    issue(op, len);
    sent = 0; got = 0; cyc = 0; hold = 0;
    occ = 1'b0; held = 1'b0;
    prev_d = '0; prev_m = '0; prev_l = 1'b0;
    while (got < beats && cyc < 2000) begin
      opnd_valid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      opnd_a     = (sent < beats) ? a_q[sent] : rand_vec(32'h00FF_FFFF);
      opnd_b     = (sent < beats) ? b_q[sent] : rand_vec(32'h00FF_FFFF);
      case (rdy_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = (hold >= 4);
      endcase
      settle();
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      chk("cmd_ready_run", cmd_ready, 1'b0);
      chk("res_valid", res_valid, occ);
      chk("opnd_ready", opnd_ready, (sent < beats) && (!occ || res_ready));
      if (held) begin
        chk("hold_data", res_data, prev_d);
        chk("hold_mask", res_lane_mask, prev_m);
        chk("hold_last", res_last, prev_l);
      end
      if (res_valid && res_ready) begin
        chk("res_data", res_data, exp_d[got]);
        chk("res_mask", res_lane_mask, exp_m[got]);
        chk("res_last", res_last, (got == beats - 1));
        got++;
      end
      if (rdy_mode == 2 && res_valid) hold++;
      ohs    = opnd_valid && opnd_ready;
      rhs    = res_valid && res_ready;
      held   = res_valid && !res_ready;
      prev_d = res_data;
      prev_m = res_lane_mask;
      prev_l = res_last;
      if (ohs) sent++;
      occ = ohs ? 1'b1 : (rhs ? 1'b0 : occ);
      tick();
      cyc++;
    end
    if (got < beats) chk("timeout_beats", got, beats);

    opnd_valid = 1'b1;
    res_ready  = 1'b0;
    settle();
    chk("done_pulse", done, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("cmd_ready_after", cmd_ready, 1'b1);
    chk("res_valid_after", res_valid, 1'b0);
    chk("opnd_ready_after", opnd_ready, 1'b0);
    opnd_valid = 1'b0;
    tick();
    chk("done_single", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    opnd_valid = 1'b1; opnd_a = '0; opnd_b = '0; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_last", res_last, 1'b0);
    chk("rst_mask", res_lane_mask, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_opnd_ready", opnd_ready, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    opnd_valid = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_data", res_data, '0);

    fill_const(2, W'(5), W'(3));
    run(0, 16, 0, 0);

    fill_const(2, W'(0), W'(1));
    run(1, 11, 0, 0);

    fill_rand(1, 2);
    run(2, 8, 0, 2);

    issue(3, 0);
    opnd_valid = 1'b1;
    settle();
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_opnd_ready", opnd_ready, 1'b0);
    chk("len0_res_valid", res_valid, 1'b0);
    opnd_valid = 1'b0;
    tick();
    chk("len0_done_single", done, 1'b0);

    fill_rand(8, 6);
    run(6, 100, 1, 1);

    fill_rand(3, 4);
    run(4, 24, 0, 0);

    // Abort a 4-beat command while its first result is held
    fill_rand(4, 0);
    issue(0, 32);
    opnd_valid = 1'b1; opnd_a = a_q[0]; opnd_b = b_q[0]; res_ready = 1'b0;
    settle();
    chk("abort_opnd_ready", opnd_ready, 1'b1);
    tick();
    opnd_valid = 1'b0;
    settle();
    chk("abort_pre_valid", res_valid, 1'b1);
    rst = 1'b1;
    settle();
    chk("abort_rst_valid", res_valid, 1'b0);
    chk("abort_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    tick();
    chk("abort_no_done", done, 1'b0);

    fill_rand(1, 3);
    run(3, 8, 0, 0);

    for (int n = 0; n < 8; n++) begin
      int op, len;
      op  = $urandom_range(0, 7);
      len = $urandom_range(1, 80);
      fill_rand(((len > ML ? ML : len) + VW - 1) / VW, op);
      run(op, len, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/valu_sequencer.md
VALU_SEQUENCER -- requirements
Module: valu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, element width in bits.
REQ-002 The block SHALL have parameter VECTOR_WIDTH, default 8, lanes per beat (lanes of the vector ALU).
REQ-003 The block SHALL have parameter MAX_LEN, default 64, maximum elements per command.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_op  in  3  ALU select: 000 add, 001 sub, 010 mult, 011 and, 100 cmp-less, 101 shiftl, 110 pass A, 111 pass B.
- cmd_len  in  7  element count.
- opnd_valid  in  1  operand beat offered.
- opnd_ready  out  1  operand beat accepted when high with opnd_valid.
- opnd_a  in  VECTOR_WIDTH x WIDTH  lane operands A.
- opnd_b  in  VECTOR_WIDTH x WIDTH  lane operands B.
- res_valid  out  1  result beat held.
- res_ready  in  1  consumer accepts result beat.
- res_data  out  VECTOR_WIDTH x WIDTH  lane results.
- res_lane_mask  out  VECTOR_WIDTH  live lanes of the current beat.
- res_last  out  1  final beat of the command.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at command completion.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN, DRAIN. cmd_ready SHALL be 1 only in IDLE.
REQ-006 On a command handshake, the block SHALL latch cmd_op and an effective length: cmd_len > MAX_LEN clamps to MAX_LEN.
REQ-007 Beat count SHALL be ceil(len/VECTOR_WIDTH). The beat counter SHALL be cleared on acceptance.
REQ-008 IDLE transitions: to RUN on handshake with len >= 1; with len == 0, stay in IDLE and pulse done the next cycle, with no beats issued.
REQ-009 In RUN, opnd_ready SHALL be !res_valid || res_ready (single-entry output register; one beat per cycle sustained).
REQ-010 On an operand handshake, the internal vector ALU result for the latched op SHALL be registered into res_data on the next edge. res_valid SHALL rise one cycle after the handshake (latency 1).
REQ-011 res_lane_mask SHALL be all ones on non-final beats. On the final beat, lanes with index < r SHALL be 1 and the rest 0, where r = len mod VECTOR_WIDTH, or VECTOR_WIDTH if that is 0. Masked lanes SHALL drive 0 in res_data.
REQ-012 res_last SHALL be 1 exactly on the beat with index beats-1.
REQ-013 Outside RUN, opnd_ready SHALL be 0. Operand beats beyond the command are not accepted.
REQ-014 On the final operand handshake, RUN SHALL transition to DRAIN.
REQ-015 DRAIN SHALL transition to IDLE on the res_last handshake, with done pulsed in the following cycle. cmd_ready is high in that same cycle.
REQ-016 res_data, res_lane_mask and res_last SHALL hold stable while res_valid && !res_ready.
REQ-017 A simultaneous result handshake and operand handshake SHALL replace the output register with no bubble.
REQ-018 ALU flags are unused, and arithmetic SHALL wrap modulo 2^WIDTH per lane.

Reset
REQ-019 When rst is high, state SHALL go to IDLE, and the counter, latched op/len and res_data SHALL clear to 0.
REQ-020 During reset, outputs SHALL be: res_valid=0, res_last=0, res_lane_mask=0, busy=0, done=0, opnd_ready=0, cmd_ready=0. cmd_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-021 Reset mid-command SHALL abort it with no done pulse. A held result beat SHALL be discarded.

Structure
REQ-022 Package vector_alu_pkg SHALL hold WIDTH, VECTOR_WIDTH, MAX_LEN, the 3-bit ALU op enum and the FSM state enum.
REQ-023 The block SHALL instantiate exactly one sub-module, the existing vector_alu, driven by opnd_a, opnd_b and the latched op. Sequencing, counting and masking are local logic.

Verification
REQ-024 Directed scenarios:
- ADD, len=16, all lanes A=5, B=3, res_ready=1 -> 2 beats of all 8 (lanes = 8), masks FF/FF, res_last on beat 1, done 1 cycle after beat 1 handshake.
- SUB, len=11, A=0, B=1 -> beat0 lanes 0xFFFFFF mask FF; beat1 lanes0-2 0xFFFFFF, lanes3-7 0, mask 07, res_last=1.
- MULT, len=8, res_ready held 0 for 4 cycles -> res_data stable, opnd_ready=0 until release; single beat, mask FF.
- len=0 -> no opnd_ready, done pulse next cycle. len=100 -> clamped to 8 beats.
- CMP, len=24, continuous valid/ready -> 3 consecutive res_valid cycles with no bubble.
- rst asserted in RUN after beat 1 of 4 -> next cycle res_valid=0, busy=0, no done; a following len=8 command completes normally.
